// File: rtl/link_pkg.sv
// Shared definitions for the board-to-board player link: frame layout constants,
// transmit FSM state type and the frame checksum.
package link_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         FRAME_LEN     = 6;
    localparam int         IDX_W         = 3;

    typedef enum logic [1:0] {
        IDLE,
        SNAP,
        SEND,
        WAIT
    } link_tx_state_t;

    function automatic logic [7:0] link_checksum(
        input logic [7:0] b1,
        input logic [7:0] b2,
        input logic [7:0] b3,
        input logic [7:0] b4
    );
        return b1 ^ b2 ^ b3 ^ b4;
    endfunction

endpackage

// File: rtl/link_tick_gen.sv
// Free-running period counter; tick is high in the last cycle of each period.
// Shared with the receive side, which uses it for timeout detection.
module link_tick_gen #(
    parameter int FRAME_PERIOD = 1083333
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int            CW   = (FRAME_PERIOD > 2) ? $clog2(FRAME_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_PERIOD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/player_link_tx.sv
// Sends one 6-byte player-state frame per game tick to the board-to-board UART:
// sync, {seq,flags}, x[11:4], {x[3:0],y[11:8]}, y[7:0], xor of bytes 1..4.
module player_link_tx
    import link_pkg::*;
#(
    parameter int         FRAME_PERIOD = 1083333,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_en,
    input  logic [11:0] pos_x,
    input  logic [11:0] pos_y,
    input  logic [3:0]  flags,
    input  logic        tx_done,
    output logic [7:0]  data_out,
    output logic        data_ready,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  overrun_cnt
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    link_tx_state_t   state_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [3:0]       seq_q;
    logic [3:0]       snap_seq_q;
    logic [3:0]       snap_flags_q;
    logic [11:0]      snap_x_q;
    logic [11:0]      snap_y_q;
    logic             pending_q;
    logic             carry_q;
    logic [7:0]       data_out_q;
    logic [7:0]       overrun_q;
    logic             data_ready_q;
    logic             busy_q;
    logic             frame_done_q;

    logic             tick;
    logic             last_done;
    logic             tick_busy;
    logic [7:0]       b1, b2, b3, b4;
    logic [7:0]       next_byte;

    link_tick_gen #(.FRAME_PERIOD(FRAME_PERIOD)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        idx_d = idx_q + 1'b1;
        b1    = {snap_seq_q, snap_flags_q};
        b2    = snap_x_q[11:4];
        b3    = {snap_x_q[3:0], snap_y_q[11:8]};
        b4    = snap_y_q[7:0];
        case (idx_d)
            3'd1:    next_byte = b1;
            3'd2:    next_byte = b2;
            3'd3:    next_byte = b3;
            3'd4:    next_byte = b4;
            3'd5:    next_byte = link_checksum(b1, b2, b3, b4);
            default: next_byte = SYNC_BYTE;
        endcase
    end

    // A tick landing on the final tx_done is handed to IDLE (carry) instead of pending.
    assign last_done = (state_q == WAIT) && tx_done && (idx_q == LAST_IDX);
    assign tick_busy = tick && (state_q != IDLE) && !last_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            seq_q        <= '0;
            snap_seq_q   <= '0;
            snap_flags_q <= '0;
            snap_x_q     <= '0;
            snap_y_q     <= '0;
            pending_q    <= 1'b0;
            carry_q      <= 1'b0;
            data_out_q   <= '0;
            data_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= '0;
        end else begin
            data_ready_q <= 1'b0;
            frame_done_q <= 1'b0;
            carry_q      <= 1'b0;
            if (tick_busy) begin
                if (!pending_q) begin
                    pending_q <= 1'b1;
                end else if (overrun_q != 8'hFF) begin
                    overrun_q <= overrun_q + 8'd1;
                end
            end
            case (state_q)
                IDLE: begin
                    if ((tick | pending_q | carry_q) & tx_en) begin
                        state_q   <= SNAP;
                        pending_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                SNAP: begin
                    snap_x_q     <= pos_x;
                    snap_y_q     <= pos_y;
                    snap_flags_q <= flags;
                    snap_seq_q   <= seq_q;
                    idx_q        <= '0;
                    data_out_q   <= SYNC_BYTE;
                    data_ready_q <= 1'b1;
                    state_q      <= SEND;
                end
                SEND: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (tx_done) begin
                        if (idx_q == LAST_IDX) begin
                            state_q      <= IDLE;
                            busy_q       <= 1'b0;
                            frame_done_q <= 1'b1;
                            seq_q        <= seq_q + 4'd1;
                            carry_q      <= tick;
                        end else begin
                            idx_q        <= idx_d;
                            data_out_q   <= next_byte;
                            data_ready_q <= 1'b1;
                            state_q      <= SEND;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out    = data_out_q;
    assign data_ready  = data_ready_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_player_link_tx.sv
// Randomised bench for player_link_tx: a UART responder, a frame-level reference
// model built on a queue of expected bytes, and directed checks from the test plan.
module tb_player_link_tx;

  localparam int P = 50;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_en;
  logic [11:0] pos_x;
  logic [11:0] pos_y;
  logic [3:0]  flags;
  logic        tx_done;
  logic [7:0]  data_out;
  logic        data_ready;
  logic        busy;
  logic        frame_done;
  logic [7:0]  overrun_cnt;

  player_link_tx #(.FRAME_PERIOD(P), .SYNC_BYTE(SYNC)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_en       (tx_en),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .flags       (flags),
    .tx_done     (tx_done),
    .data_out    (data_out),
    .data_ready  (data_ready),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun_cnt (overrun_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: bytes still owed for the frame in flight, plus frame-level flags
  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  int         m_cnt;
  bit         m_act, m_snapnext, m_strobed, m_waiting, m_pend, m_carry;
  logic [3:0] m_seq;
  int         m_ovr;
  logic       e_dr, e_busy, e_fd;
  logic [7:0] e_do;

  // UART responder
  int uart_cnt = 0;
  int delay = 10;
  bit spur_en = 0;
  bit cap_on = 0;
  int n_strobe = 0;

  task automatic model_edge();
    bit tick, fin;
    logic [7:0] b1, b2, b3, b4;
    if (rst) begin
      m_cnt = 0; m_act = 0; m_snapnext = 0; m_strobed = 0; m_waiting = 0;
      m_pend = 0; m_carry = 0; m_seq = '0; m_ovr = 0;
      exp_q.delete();
      e_dr = 0; e_do = '0; e_busy = 0; e_fd = 0;
      return;
    end
    tick = (m_cnt == P - 1);
    m_cnt = (m_cnt + 1) % P;
    fin = m_waiting && tx_done && (exp_q.size() == 0);
    e_dr = 0;
    e_fd = 0;
    if (m_act && !fin && tick) begin
      if (!m_pend) m_pend = 1;
      else if (m_ovr < 255) m_ovr++;
    end
    if (!m_act) begin
      if ((tick || m_pend || m_carry) && tx_en) begin
        m_act = 1; m_snapnext = 1; m_pend = 0; e_busy = 1;
      end
      m_carry = 0;
    end else if (m_snapnext) begin
      b1 = {m_seq, flags};
      b2 = pos_x[11:4];
      b3 = {pos_x[3:0], pos_y[11:8]};
      b4 = pos_y[7:0];
      exp_q.delete();
      exp_q.push_back(b1);
      exp_q.push_back(b2);
      exp_q.push_back(b3);
      exp_q.push_back(b4);
      exp_q.push_back(b1 ^ b2 ^ b3 ^ b4);
      e_do = SYNC; e_dr = 1; m_snapnext = 0; m_strobed = 1;
    end else if (m_strobed) begin
      m_strobed = 0; m_waiting = 1;
    end else if (m_waiting && tx_done) begin
      m_waiting = 0;
      if (fin) begin
        m_act = 0; e_busy = 0; e_fd = 1; m_seq = m_seq + 4'd1; m_carry = tick;
      end else begin
        e_do = exp_q.pop_front(); e_dr = 1; m_strobed = 1;
      end
    end
  endtask

  // one cycle: compare at negedge, then drive the UART response for the coming edge
  task automatic step();
    @(negedge clk);
    check("data_ready", 32'(data_ready), 32'(e_dr));
    check("data_out", 32'(data_out), 32'(e_do));
    check("busy", 32'(busy), 32'(e_busy));
    check("frame_done", 32'(frame_done), 32'(e_fd));
    check("overrun_cnt", 32'(overrun_cnt), 32'(m_ovr));
    if (data_ready) begin
      n_strobe++;
      if (cap_on) cap_q.push_back(data_out);
    end
    tx_done = 1'b0;
    if (uart_cnt > 0) begin
      uart_cnt--;
      if (uart_cnt == 0) tx_done = 1'b1;
    end
    if (data_ready) uart_cnt = delay;
    if (spur_en && $urandom_range(63) == 0) tx_done = 1'b1;
  endtask

  task automatic rand_inputs();
    pos_x = 12'($urandom_range(4095));
    pos_y = 12'($urandom_range(4095));
    flags = 4'($urandom_range(15));
  endtask

  task automatic run(input int n, input int dmin, input int dmax, input int chg_mod,
                     input int rst_mod, input int en_mod);
    for (int i = 0; i < n; i++) begin
      step();
      rst = 1'b0;
      delay = $urandom_range(dmax, dmin);
      if (chg_mod > 0 && $urandom_range(chg_mod - 1) == 0) rand_inputs();
      if (rst_mod > 0 && $urandom_range(rst_mod - 1) == 0) rst = 1'b1;
      if (en_mod > 0 && $urandom_range(en_mod - 1) == 0) tx_en = ~tx_en;
      model_edge();
    end
  endtask

  task automatic pulse_reset();
    step();
    rst = 1'b1;
    model_edge();
    step();
    rst = 1'b0;
    model_edge();
  endtask

  initial begin
    int guard;
    rst = 1'b1; tx_en = 1'b0; tx_done = 1'b0;
    pos_x = '0; pos_y = '0; flags = '0;
    model_edge();
    step();
    model_edge();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_data_out", 32'(data_out), 32'd0);
    check("reset_overrun", 32'(overrun_cnt), 32'd0);

    // first frames with fixed inputs: known bytes, seq increments and wraps
    step();
    rst = 1'b0; tx_en = 1'b1;
    pos_x = 12'h123; pos_y = 12'h2B4; flags = 4'h5;
    cap_on = 1;
    model_edge();
    run(1400, 10, 10, 0, 0, 0);
    cap_on = 0;
    check("cap_len", 32'(cap_q.size() >= 102), 32'd1);
    check("f0_b0", 32'(cap_q[0]), 32'hA5);
    check("f0_b1", 32'(cap_q[1]), 32'h05);
    check("f0_b2", 32'(cap_q[2]), 32'h12);
    check("f0_b3", 32'(cap_q[3]), 32'h32);
    check("f0_b4", 32'(cap_q[4]), 32'hB4);
    check("f0_b5", 32'(cap_q[5]), 32'h91);
    check("f1_b1", 32'(cap_q[7]), 32'h15);
    check("f1_b5", 32'(cap_q[11]), 32'h81);
    check("f16_b1", 32'(cap_q[97]), 32'h05);

    // random inputs changing mid-frame, random UART delay, stray tx_done pulses
    spur_en = 1;
    run(3000, 2, 12, 40, 0, 0);
    spur_en = 0;

    // tx_en low for 500 cycles: no strobes; then a restart (sometimes from pending)
    for (int r = 0; r < 3; r++) begin
      guard = 0;
      while (m_act && guard < 2000) begin
        run(1, 2, 60, 0, 0, 0);
        guard++;
      end
      check("idle_wait", 32'(m_act), 32'd0);
      step();
      tx_en = 1'b0;
      rand_inputs();
      model_edge();
      n_strobe = 0;
      run(500, 2, 12, 30, 0, 0);
      check("en_low_strobes", 32'(n_strobe), 32'd0);
      step();
      tx_en = 1'b1;
      model_edge();
      run(300, 2, 30, 30, 0, 0);
    end

    // overrun: 40-cycle bytes give 3 dropped ticks by cycle 250, then saturation
    pulse_reset();
    run(259, 40, 40, 0, 0, 0);
    check("overrun_250", 32'(overrun_cnt), 32'd3);
    run(20000, 50, 50, 0, 0, 0);
    check("overrun_sat", 32'(overrun_cnt), 32'd255);

    // random resets and tx_en toggles mid-frame
    spur_en = 1;
    run(3000, 2, 20, 50, 250, 200);
    spur_en = 0;

    // reset during byte 3's wait; late tx_done ignored; restart from byte 0 with seq 0
    step();
    tx_en = 1'b1;
    pos_x = 12'h123; pos_y = 12'h2B4; flags = 4'h5;
    model_edge();
    guard = 0;
    while (!(m_waiting && exp_q.size() == 2) && guard < 3000) begin
      run(1, 10, 10, 0, 0, 0);
      guard++;
    end
    check("byte3_wait", 32'(m_waiting && exp_q.size() == 2), 32'd1);
    step();
    rst = 1'b1;
    model_edge();
    step();
    rst = 1'b0;
    model_edge();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    cap_q.delete();
    cap_on = 1;
    run(150, 10, 10, 0, 0, 0);
    cap_on = 0;
    check("rst_f_b0", 32'(cap_q[0]), 32'hA5);
    check("rst_f_b1", 32'(cap_q[1]), 32'h05);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/player_link_tx.md
Name: player_link_tx

Overview:
Serialises the local player's state into a fixed 6-byte frame and hands it, one byte at a time, to the board-to-board UART transmitter. It emits one frame per game tick. It is the sending end of the inter-board link whose receive side feeds the game's data_in/data_ready. It sits between move_ctr_fsm / read_keyboard and the UART TX core.

Parameters:
FRAME_PERIOD, 1083333, clk cycles between frame starts (65 MHz / 60 Hz); must be >= 2.
SYNC_BYTE, 8'hA5, frame start marker.

Ports:
clk  in  1  system clock (65 MHz domain).
rst  in  1  reset.
tx_en  in  1  enables frame generation; when low, no new frame starts.
pos_x  in  12  player x position.
pos_y  in  12  player y position.
flags  in  4  {alive, jump, left, right}.
tx_done  in  1  one-cycle pulse from UART TX when the current byte has finished.
data_out  out  8  byte to transmit.
data_ready  out  1  one-cycle strobe; data_out is valid in that cycle.
busy  out  1  high while a frame is in progress.
frame_done  out  1  one-cycle pulse after the last byte's tx_done.
overrun_cnt  out  8  saturating count of dropped ticks.

Interface: one clock, clk. Reset rst is synchronous and active-high.

Behaviour:
- Reset values:
  - data_out=0, data_ready=0, busy=0, frame_done=0, overrun_cnt=0.
  - Internal seq=0, period counter=0, pending=0, FSM=IDLE.
- Period counter:
  - Free-running 0..FRAME_PERIOD-1, then wraps to 0.
  - tick=1 in the cycle the counter equals FRAME_PERIOD-1.
  - Runs regardless of tx_en.
- Frame layout (bytes 0..5):
  - Byte 0: SYNC_BYTE.
  - Byte 1: {seq[3:0], flags}.
  - Byte 2: pos_x[11:4].
  - Byte 3: {pos_x[3:0], pos_y[11:8]}.
  - Byte 4: pos_y[7:0].
  - Byte 5: XOR of bytes 1..4.
- FSM states IDLE, SNAP, SEND, WAIT:
  - IDLE: if (tick | pending) & tx_en, go to SNAP and clear pending. Otherwise stay.
  - SNAP: latch pos_x, pos_y, flags, seq into a snapshot register; byte index=0; busy=1; go to SEND.
  - SEND: data_out=frame[idx]; data_ready=1 for exactly this cycle; go to WAIT.
  - WAIT:
    - tx_done while idx<5: idx+1, go to SEND.
    - tx_done while idx==5: frame_done=1 next cycle, busy=0, seq+1 (mod 16), go to IDLE.
- Latency:
  - Byte 0's data_ready is asserted 2 cycles after the tick cycle (tick in IDLE at cycle T: SNAP at T+1, SEND at T+2).
  - Byte k+1's data_ready is asserted the cycle after byte k's tx_done.
- data_out holds its value until the next SEND; it is not cleared after the strobe.
- Input changes after SNAP do not affect the frame in flight. The checksum is computed from the snapshot only.
- tx_done outside WAIT is ignored.
- Tick while busy (SNAP/SEND/WAIT):
  - If pending=0, set pending=1.
  - If pending=1, the tick is dropped and overrun_cnt+1 (saturates at 255).
- Pending with tx_en low: pending is held until tx_en returns high.
- tx_en falling mid-frame: the current frame completes. No new frame starts while tx_en is low.
- Tick in the same cycle the FSM returns to IDLE: counts as a tick seen in IDLE, so the next frame starts normally. No pending is set and no overrun is counted.
- rst mid-frame: the FSM aborts to IDLE and all outputs return to reset values the next cycle. No partial frame is resumed.

Decomposition:
- Package link_pkg holds:
  - SYNC_BYTE default, FRAME_LEN=6, byte-index width.
  - typedef enum logic [1:0] {IDLE, SNAP, SEND, WAIT} link_tx_state_t.
  - function link_checksum(b1..b4).
- Sub-module link_tick_gen (parameter FRAME_PERIOD; ports clk, rst, tick) holds the period counter. It is reused by the receive side for timeout detection.

Test Plan:
1. FRAME_PERIOD=50, tx_en=1, pos_x=12'h123, pos_y=12'h2B4, flags=4'h5, UART model returns tx_done 10 cycles after each strobe -> bytes A5,05,12,32,B4,91. First data_ready at tick+2. frame_done once. busy low afterwards.
2. Second frame with unchanged inputs -> byte1=8'h15 (seq=1), checksum=8'h81. After 16 frames, seq wraps to 0 and byte1=8'h05.
3. Change pos_x to 12'hFFF while byte 2 is in WAIT -> current frame still carries 12/32. The next frame carries FF/F2.
4. UART delay 40 cycles/byte (frame 240 cycles > period 50) -> at most one back-to-back frame from pending. overrun_cnt increments per dropped tick, ends 3 after 250 cycles, and saturates at 255 on a long run.
5. tx_en=0 -> no data_ready for 500 cycles. Raising tx_en starts a frame at the next tick, or 2 cycles after tx_en rises if pending is set.
6. Assert rst for 1 cycle during byte 3's WAIT -> next cycle busy=0, data_out=0, seq=0. A late tx_done causes no strobe. The next tick restarts from byte 0 with byte1=8'h05.
